// File: rtl/scan_txn_pkg.sv
// Shared types and frame layout for the scan transaction controller.
package scan_txn_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // Frame layout: {wr/status, addr[10:0], data[31:0]}
  localparam int FRAME_W = 44;
  localparam int WR_BIT  = 43;
  localparam int ADDR_HI = 42;
  localparam int ADDR_LO = 32;
  localparam int DATA_HI = 31;
  localparam int DATA_LO = 0;

  // Timeout counter width; covers TIMEOUT up to 255.
  localparam int CNT_W = 8;

  // Control register set; doubles as the observable FSM state bundle.
  typedef struct packed {
    state_t           state;
    logic             busy;
    logic             ren;
    logic             wen;
    logic             wr;
    logic [CNT_W-1:0] cnt;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{
    state: IDLE,
    busy:  1'b0,
    ren:   1'b0,
    wen:   1'b0,
    wr:    1'b0,
    cnt:   '0
  };

endpackage

// File: rtl/scan_pin_sync.sv
// Multi-flop synchroniser for one asynchronous scan pin. With RISE_DET set,
// the output is a registered one-cycle pulse on each synchronised rising
// edge; otherwise it is the synchronised level. SYNC_STAGES must be >= 2.
module scan_pin_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit RISE_DET    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  // Shift the raw pin through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], pin};
    end
  end

  if (RISE_DET) begin : g_rise
    logic prev;
    logic pulse;

    // Remember the last synchronised level and register the rise pulse.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prev  <= 1'b0;
        pulse <= 1'b0;
      end else begin
        prev  <= stages[SYNC_STAGES-1];
        pulse <= stages[SYNC_STAGES-1] & ~prev;
      end
    end

    assign q = pulse;
  end else begin : g_level
    assign q = stages[SYNC_STAGES-1];
  end

endmodule

// File: rtl/scan_txn_ctrl.sv
// Scan-pin transaction controller: shifts a 44-bit frame in from the host,
// issues one read or write on the scan request bus per update strobe, and
// loads read data plus a status bit back into the frame.
//
// Request handshake: scan_ren/scan_wen (exactly one) stay high, with
// scan_addr/scan_wdata stable, until the first cycle scan_ready is sampled
// high or the timeout count is reached; the request drops the following
// cycle. scan_rdata is sampled in that same final cycle.
module scan_txn_ctrl
  import scan_txn_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_clk_i,
  input  logic              scan_en_i,
  input  logic              scan_in_i,
  input  logic              scan_update_i,
  output logic              scan_out_o,
  output logic              scan_ren,
  output logic              scan_wen,
  output logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_wdata,
  input  logic [DATA_W-1:0] scan_rdata,
  input  logic              scan_ready,
  output logic              busy_o
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic clk_rise;
  logic upd_rise;
  logic en_s;
  logic in_s;

  scan_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RISE_DET(1'b1)) u_sync_clk (
    .clk(clk), .rst_n(rst_n), .pin(scan_clk_i), .q(clk_rise)
  );
  scan_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RISE_DET(1'b1)) u_sync_upd (
    .clk(clk), .rst_n(rst_n), .pin(scan_update_i), .q(upd_rise)
  );
  scan_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RISE_DET(1'b0)) u_sync_en (
    .clk(clk), .rst_n(rst_n), .pin(scan_en_i), .q(en_s)
  );
  scan_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RISE_DET(1'b0)) u_sync_in (
    .clk(clk), .rst_n(rst_n), .pin(scan_in_i), .q(in_s)
  );

  ctrl_t              ctrl_q, ctrl_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_inc;

  assign cnt_inc = ctrl_q.cnt + 1'b1;

  // State, frame and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= CTRL_RST;
      frame_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      frame_q <= frame_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state logic: shift and launch in IDLE, wait for ready/timeout in REQ.
  always_comb begin
    ctrl_d  = ctrl_q;
    frame_d = frame_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (ctrl_q.state)
      IDLE: begin
        if (clk_rise && en_s) begin
          frame_d = {frame_q[FRAME_W-2:0], in_s};
        end
        // Launch from the pre-shift frame even if a shift lands this cycle.
        if (upd_rise) begin
          ctrl_d.state = REQ;
          ctrl_d.busy  = 1'b1;
          ctrl_d.wr    = frame_q[WR_BIT];
          ctrl_d.ren   = ~frame_q[WR_BIT];
          ctrl_d.wen   = frame_q[WR_BIT];
          ctrl_d.cnt   = '0;
          addr_d       = frame_q[ADDR_HI:ADDR_LO];
          wdata_d      = frame_q[DATA_HI:DATA_LO];
        end
      end
      REQ: begin
        // Shift and update edges are dropped here.
        if (scan_ready || (cnt_inc == TIMEOUT_C)) begin
          ctrl_d.state    = IDLE;
          ctrl_d.busy     = 1'b0;
          ctrl_d.ren      = 1'b0;
          ctrl_d.wen      = 1'b0;
          frame_d[WR_BIT] = ~scan_ready;
          // Reads capture data even on timeout (status regs never ack).
          if (!ctrl_q.wr) begin
            frame_d[DATA_HI:DATA_LO] = scan_rdata;
          end
        end else begin
          ctrl_d.cnt = cnt_inc;
        end
      end
      default: begin
        ctrl_d.state = IDLE;
      end
    endcase
  end

  assign scan_out_o = frame_q[WR_BIT];
  assign scan_ren   = ctrl_q.ren;
  assign scan_wen   = ctrl_q.wen;
  assign busy_o     = ctrl_q.busy;
  assign scan_addr  = addr_q;
  assign scan_wdata = wdata_q;

endmodule

// File: tb/tb_scan_txn_ctrl.sv
// Bench for scan_txn_ctrl: directed vector table, randomized transactions
// against a rule-level model, and hand-written reset/lockout/edge sequences.
module tb_scan_txn_ctrl;

  localparam int ADDR_W      = 11;
  localparam int DATA_W      = 32;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 15;
  localparam int LAT         = SYNC_STAGES + 2;

  logic              clk;
  logic              rst_n;
  logic              scan_clk_i, scan_en_i, scan_in_i, scan_update_i;
  logic              scan_out_o, scan_ren, scan_wen, scan_ready, busy_o;
  logic [ADDR_W-1:0] scan_addr;
  logic [DATA_W-1:0] scan_wdata, scan_rdata;

  scan_txn_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .scan_clk_i(scan_clk_i), .scan_en_i(scan_en_i), .scan_in_i(scan_in_i),
    .scan_update_i(scan_update_i), .scan_out_o(scan_out_o),
    .scan_ren(scan_ren), .scan_wen(scan_wen), .scan_addr(scan_addr),
    .scan_wdata(scan_wdata), .scan_rdata(scan_rdata), .scan_ready(scan_ready),
    .busy_o(busy_o)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got time limit expired, required run completion");
    $fatal(1, "watchdog expired");
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [43:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic [10:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    int          delay;
    int          exp_cycles;
    logic        exp_status;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: request length and the frame left behind.
  function automatic int ref_cycles(input int delay);
    return (delay < TIMEOUT) ? delay + 1 : TIMEOUT;
  endfunction

  function automatic logic [43:0] ref_frame(input logic [43:0] f, input logic wr,
                                            input logic [31:0] rdata, input int delay);
    logic [43:0] r;
    r = f;
    r[43] = (delay >= TIMEOUT);
    if (!wr) r[31:0] = rdata;
    return r;
  endfunction

  // Driver: one scan bit, returning scan_out_o as seen before the shift.
  task automatic shift_bit(input logic b, output logic o);
    @(negedge clk);
    scan_in_i  = b;
    scan_clk_i = 1'b0;
    repeat (4) @(negedge clk);
    o = scan_out_o;
    scan_clk_i = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic shift_frame(input logic [43:0] new_f, output logic [43:0] old_f);
    logic [43:0] o;
    scan_en_i = 1'b1;
    for (int i = 43; i >= 0; i--) shift_bit(new_f[i], o[i]);
    @(negedge clk);
    scan_clk_i = 1'b0;
    repeat (4) @(negedge clk);
    scan_en_i = 1'b0;
    old_f = o;
  endtask

  // Load a new frame while checking the previous one against the scoreboard.
  task automatic load_frame(input logic [43:0] f);
    logic [43:0] old;
    logic [43:0] exp;
    shift_frame(f, old);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 44'h0;
    check("frame_readback", old, exp);
  endtask

  // Driver + monitor for one transaction.
  // mode 0: plain; 1: shift/update noise during REQ; 2: reset mid-REQ.
  task automatic run_txn(input logic wr, input logic [10:0] addr, input logic [31:0] data,
                         input logic [31:0] rdata, input int delay, input int mode,
                         input bit sim_edge, input bit sim_bit, output int cycles);
    int          lat;
    int          extra;
    bit          seen, aborted;
    logic [10:0] act_addr;
    logic [31:0] act_wdata;
    logic [1:0]  act_kind;
    logic        act_busy;
    act_addr = addr; act_wdata = data; act_kind = {~wr, wr}; act_busy = 1'b1;
    cycles = 0; lat = 0; seen = 0; aborted = 0; extra = 0;
    scan_rdata = rdata;
    scan_ready = 1'b0;
    @(negedge clk);
    scan_update_i = 1'b1;
    if (sim_edge) begin
      scan_en_i  = 1'b1;
      scan_in_i  = sim_bit;
      scan_clk_i = 1'b1;
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (scan_ren || scan_wen) begin
        lat = i;
        seen = 1;
        break;
      end
    end
    check("req_latency", lat, LAT);
    while (seen && !aborted && (scan_ren || scan_wen) && cycles < 300) begin
      cycles++;
      if (scan_addr !== addr && act_addr === addr) act_addr = scan_addr;
      if (scan_wdata !== data && act_wdata === data) act_wdata = scan_wdata;
      if ({scan_ren, scan_wen} !== {~wr, wr}) act_kind = {scan_ren, scan_wen};
      if (busy_o !== 1'b1) act_busy = 1'b0;
      if (mode == 1 && cycles <= 10) begin
        scan_en_i  = 1'b1;
        scan_in_i  = 1'b1;
        scan_clk_i = (cycles % 2 == 1);
        if (cycles == 2) scan_update_i = 1'b0;
        if (cycles == 6) scan_update_i = 1'b1;
      end
      if (mode == 2 && cycles == 3) begin
        rst_n = 1'b0;
        #1;
        check("rst_req_wen", scan_wen, 1'b0);
        check("rst_req_ren", scan_ren, 1'b0);
        check("rst_req_busy", busy_o, 1'b0);
        check("rst_req_addr", scan_addr, '0);
        check("rst_req_scan_out", scan_out_o, 1'b0);
        aborted = 1;
      end else begin
        scan_ready = (cycles == delay + 1);
        @(negedge clk);
      end
    end
    scan_ready = 1'b0; scan_clk_i = 1'b0; scan_en_i = 1'b0; scan_update_i = 1'b0;
    if (aborted) begin
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
    end else begin
      check("req_addr", act_addr, addr);
      check("req_wdata", act_wdata, data);
      check("req_kind", act_kind, {~wr, wr});
      check("busy_in_req", act_busy, 1'b1);
      check("busy_after_req", busy_o, 1'b0);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (scan_ren || scan_wen) extra++;
      end
      check("single_txn", extra, 0);
    end
  endtask

  initial begin
    int          cyc;
    logic        o;
    logic        wr;
    logic [10:0] addr;
    logic [31:0] data, rdata;
    int          delay;
    logic [43:0] f;

    vecs[0] = '{1'b1, 11'h004, 32'hDEADBEEF, 32'h12345678, 1,   2,  1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 11'h600, 32'hAAAA5555, 32'h00000005, 3,   4,  1'b0, 32'h00000005};
    vecs[2] = '{1'b0, 11'h440, 32'h00000000, 32'h00000001, 255, 15, 1'b1, 32'h00000001};
    vecs[3] = '{1'b0, 11'h7FF, 32'hFFFFFFFF, 32'h00000000, 0,   1,  1'b0, 32'h00000000};
    vecs[4] = '{1'b1, 11'h123, 32'h0F0F0F0F, 32'hCAFEF00D, 14,  15, 1'b0, 32'h0F0F0F0F};
    vecs[5] = '{1'b1, 11'h001, 32'h80000001, 32'h00000000, 255, 15, 1'b1, 32'h80000001};
    vecs[6] = '{1'b0, 11'h3FE, 32'h11111111, 32'hFEEDFACE, 15,  15, 1'b1, 32'hFEEDFACE};

    // Reset block.
    rst_n = 1'b0; scan_clk_i = 1'b0; scan_en_i = 1'b0; scan_in_i = 1'b0;
    scan_update_i = 1'b0; scan_ready = 1'b0; scan_rdata = '0;
    repeat (3) @(negedge clk);
    check("reset_ren", scan_ren, 1'b0);
    check("reset_wen", scan_wen, 1'b0);
    check("reset_addr", scan_addr, '0);
    check("reset_wdata", scan_wdata, '0);
    check("reset_busy", busy_o, 1'b0);
    check("reset_scan_out", scan_out_o, 1'b0);
    rst_n = 1'b1;

    // Fill the frame with ones, then reset in the middle of the next shift.
    exp_q.push_back(44'h0);
    load_frame({44{1'b1}});
    scan_en_i = 1'b1;
    for (int i = 0; i < 3; i++) shift_bit(1'b0, o);
    @(negedge clk);
    scan_clk_i = 1'b0;
    repeat (2) @(negedge clk);
    scan_clk_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_shift_scan_out", scan_out_o, 1'b0);
    check("rst_shift_busy", busy_o, 1'b0);
    scan_clk_i = 1'b0; scan_en_i = 1'b0; scan_in_i = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(44'h0);

    // Directed table.
    for (int v = 0; v < 7; v++) begin
      load_frame({vecs[v].wr, vecs[v].addr, vecs[v].data});
      run_txn(vecs[v].wr, vecs[v].addr, vecs[v].data, vecs[v].rdata, vecs[v].delay, 0, 0, 0, cyc);
      check("tbl_req_cycles", cyc, vecs[v].exp_cycles);
      exp_q.push_back({vecs[v].exp_status, vecs[v].addr, vecs[v].exp_data});
    end

    // Randomized transactions against the reference model.
    for (int n = 0; n < 12; n++) begin
      wr    = 1'($urandom_range(0, 1));
      addr  = 11'($urandom);
      data  = $urandom;
      rdata = $urandom;
      delay = $urandom_range(0, 20);
      f = {wr, addr, data};
      load_frame(f);
      run_txn(wr, addr, data, rdata, delay, 0, 0, 0, cyc);
      check("rnd_req_cycles", cyc, ref_cycles(delay));
      exp_q.push_back(ref_frame(f, wr, rdata, delay));
    end

    // Busy lockout: shift clocks and a second update during REQ are dropped.
    f = {1'b0, 11'h2A5, 32'h0BADF00D};
    load_frame(f);
    run_txn(1'b0, 11'h2A5, 32'h0BADF00D, 32'h76543210, 14, 1, 0, 0, cyc);
    check("lockout_req_cycles", cyc, 15);
    exp_q.push_back(ref_frame(f, 1'b0, 32'h76543210, 14));

    // Shift and update edges in the same cycle: launch uses pre-shift frame.
    f = {1'b1, 11'h155, 32'h13579BDF};
    load_frame(f);
    run_txn(1'b1, 11'h155, 32'h13579BDF, 32'h99999999, 2, 0, 1, 1'b1, cyc);
    check("sim_req_cycles", cyc, 3);
    exp_q.push_back(ref_frame({f[42:0], 1'b1}, 1'b1, 32'h99999999, 2));

    // Reset while a write is outstanding: no capture, frame cleared.
    load_frame({1'b1, 11'h7A0, 32'h5A5A5A5A});
    run_txn(1'b1, 11'h7A0, 32'h5A5A5A5A, 32'h0, 255, 2, 0, 0, cyc);
    exp_q.push_back(44'h0);

    // Final readback.
    load_frame(44'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scan_txn_ctrl.md
Name: scan_txn_ctrl

Overview:
- Upstream of the scan-side mem/reg mux. Deserialises a 44-bit scan frame from slow off-chip scan pins, all sampled in the core clock domain.
- On an update strobe it issues one read or write on the scan_* request bus and waits for scan_ready, bounded by a timeout.
- It then loads read data and status back into the frame so the host can shift them out.

Parameters:
- ADDR_W, 11: scan address width; bit 10 selects SRAM (0) or registers (1).
- DATA_W, 32: scan data width.
- SYNC_STAGES, 2: flops in each pin synchroniser; minimum 2.
- TIMEOUT, 15: cycles in REQ without scan_ready before abort; range 1..255.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- scan_clk_i  in  1  host scan clock, asynchronous; sampled as data.
- scan_en_i  in  1  shift enable, asynchronous.
- scan_in_i  in  1  serial data in, asynchronous.
- scan_update_i  in  1  transaction strobe, asynchronous.
- scan_out_o  out  1  serial data out (frame bit 43).
- scan_ren  out  1  read request to the mux.
- scan_wen  out  1  write request to the mux.
- scan_addr  out  ADDR_W  request address.
- scan_wdata  out  DATA_W  write data.
- scan_rdata  in  DATA_W  read data from the mux (combinational).
- scan_ready  in  1  target acknowledge.
- busy_o  out  1  high while in REQ.

Behaviour:
- Frame register `frame[43:0]`:
  - bit 43 = wr flag (1 = write).
  - bits [42:32] = addr.
  - bits [31:0] = data.
- Synchronisers: scan_clk_i, scan_en_i, scan_in_i and scan_update_i each pass through SYNC_STAGES flops. A further flop on the synchronised scan_clk and scan_update provides rise-edge detection.
- Shift: on a synchronised scan_clk rising edge with sync scan_en = 1 and state IDLE, `frame <= {frame[42:0], sync scan_in}`. scan_out_o = frame[43], registered, so it changes only on shift or capture.
- Shift edges while in REQ are dropped; the frame is unchanged.
- State machine: two states, IDLE and REQ.
  - IDLE → REQ on an update rise edge.
  - On that entry cycle: latch addr and data from the frame into scan_addr and scan_wdata; latch frame[43] into the wr register; clear the timeout counter.
  - If shift and update rise edges coincide in the same cycle, the shift takes effect and the transaction uses the pre-shift frame.
- REQ outputs:
  - scan_ren = ~wr and scan_wen = wr, both held high for every REQ cycle.
  - scan_addr and scan_wdata are stable throughout REQ.
  - busy_o = 1.
- REQ exit on scan_ready = 1 → IDLE, next cycle:
  - Read: frame[31:0] <= scan_rdata, sampled in the same cycle as scan_ready.
  - Write: frame[31:0] is unchanged.
  - frame[43] <= 0 (status OK); frame[42:32] is unchanged.
  - Requests deassert in the cycle after ready, i.e. requests are high for exactly N+1 cycles, where N = cycles before ready.
- REQ exit on timeout: the counter increments each REQ cycle without ready. When the count reaches TIMEOUT, the block goes to IDLE:
  - Read: frame[31:0] <= scan_rdata regardless. This is required for status addresses such as the fft_done read, which returns data but never asserts ready.
  - frame[43] <= 1 (timeout flag).
- Update rise edges during REQ are ignored and not queued.
- Reset values: frame = 0, state IDLE, scan_ren = scan_wen = 0, scan_addr = 0, scan_wdata = 0, busy_o = 0, scan_out_o = 0, all synchroniser and edge flops = 0.
- Reset mid-REQ: requests drop immediately (asynchronous reset) and no capture occurs.
- scan_ren and scan_wen are never both high. All outputs are registered.
- Latency from the scan_update_i pin edge to scan_ren/scan_wen high is SYNC_STAGES + 2 clk cycles.

Decomposition:
- Package scan_txn_pkg holds:
  - state enum {IDLE, REQ};
  - FRAME_W = 44, WR_BIT = 43;
  - localparams for the addr and data field bounds.
- One sub-module, scan_pin_sync: a SYNC_STAGES synchroniser plus rise-edge detect. Instantiate it for scan_clk and scan_update; use the plain synchroniser only for scan_en and scan_in.

Test Plan:
- Reset: hold rst_n = 0 mid-shift → all outputs 0, frame = 0. Assert rst_n = 0 while in REQ → scan_wen falls in the same cycle.
- Write: shift frame wr = 1, addr = 0x004, data = 0xDEADBEEF, then pulse update; ready returns 1 cycle later → scan_wen high for 2 cycles, scan_addr = 0x004, scan_wdata = 0xDEADBEEF. The following 44 shifts out bit 43 = 0 and data = 0xDEADBEEF.
- Read: frame wr = 0, addr = 0x600, scan_rdata = 0x00000005, ready at cycle 3 → scan_ren high for 4 cycles; shifted-out data = 0x5, bit 43 = 0.
- Timeout: frame wr = 0, addr = 0x440, ready never asserted, scan_rdata = 0x1 → scan_ren high for exactly TIMEOUT = 15 cycles; shift-out gives bit 43 = 1 and data = 0x00000001.
- Busy lockout: during REQ, toggle scan_clk 5 times and pulse update again → frame unchanged, exactly one transaction issued, busy_o high throughout REQ.
- Simultaneous edges: shift edge and update edge in the same cycle → the transaction uses the pre-shift addr/data, and frame[0] takes the new bit.
